shiftadd_dot_seq: RTL and testbench

- Dot-product sequencer that wraps the 4x4 shift-add multiplier.
- Upstream side: accepts 4-bit operand pairs on a valid/ready stream.
- Multiplier side: issues each pair to the multiplier via start/a/b, captures the 8-bit product on the flag pulse, and adds it into a running sum.
- Downstream side: on the pair marked in_last, or at MAX_LEN pairs, presents sum and pair count on a valid/ready output.

---
 rtl/shiftadd_dot_seq.sv | 190 +++++++++++++++++++
 tb/tb_shiftadd_dot_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftadd_dot_seq.sv
// ============================================================================
// shiftadd_dot_seq
//
// Dot-product sequencer in front of a 4x4 shift-add multiplier. Operand pairs
// arrive on a valid/ready stream. Each pair goes to the multiplier through
// mul_start/mul_a/mul_b. The 8-bit product is captured on the mul_flag pulse
// and added into a running sum. The result is presented on a valid/ready
// output when the pair marked in_last has been accumulated, or when MAX_LEN
// pairs have been accumulated (out_trunc is then set if in_last never came).
//
// Optional feature (macro SHIFTADD_DOT_TIMEOUT_EN):
//   A watchdog counts cycles in WAIT. After TMO_CYC cycles with no mul_flag
//   it sets the sticky err flag, drops the vector and returns to GUARD.
//   Without the macro, err is tied to 0 and WAIT waits indefinitely.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operand pair valid          o_in_ready  pair accepted when high
//   i_in_a/b     4-bit operands              i_in_last   final pair of vector
//   o_mul_start  one-cycle start pulse       o_mul_a/b   registered operands
//   i_mul_flag   multiplier done pulse       i_mul_prod  8-bit product
//   o_out_valid  result valid                i_out_ready consumer accepts result
//   o_out_sum    dot-product sum             o_out_cnt   pairs accumulated
//   o_out_trunc  vector cut at MAX_LEN       o_err       sticky watchdog error
// ============================================================================
module shiftadd_dot_seq #(
   parameter int MAX_LEN   = 16,
   parameter int CNT_W     = 5,
   parameter int SUM_W     = 12,
   parameter int GUARD_CYC = 10,
   parameter int TMO_CYC   = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [3:0]       i_in_a,
   input  logic [3:0]       i_in_b,
   input  logic             i_in_last,
   output logic             o_mul_start,
   output logic [3:0]       o_mul_a,
   output logic [3:0]       o_mul_b,
   input  logic             i_mul_flag,
   input  logic [7:0]       i_mul_prod,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [SUM_W-1:0] o_out_sum,
   output logic [CNT_W-1:0] o_out_cnt,
   output logic             o_out_trunc,
   output logic             o_err
);

   // One cycle counter serves both the GUARD delay and the WAIT watchdog;
   // these two states never overlap, so a single counter is enough.
   localparam int TICK_MAX = (GUARD_CYC > TMO_CYC) ? GUARD_CYC : TMO_CYC;
   localparam int TW       = $clog2(TICK_MAX + 1);

   typedef enum logic [2:0] {
      S_GUARD,
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [TW-1:0]    r_tick_cnt;
   logic             r_last;
   logic [SUM_W-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_trunc;
   logic             r_in_ready;
   logic             r_mul_start;
   logic [3:0]       r_mul_a;
   logic [3:0]       r_mul_b;
   logic             r_out_valid;

   logic [CNT_W-1:0] w_cnt_inc;
   logic [SUM_W-1:0] w_sum_add;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_sum_add = r_sum + {{(SUM_W-8){1'b0}}, i_mul_prod};

`ifdef SHIFTADD_DOT_TIMEOUT_EN
   logic r_err;
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_GUARD;
         r_tick_cnt  <= '0;
         r_last      <= 1'b0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_trunc     <= 1'b0;
         r_in_ready  <= 1'b0;
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_out_valid <= 1'b0;
`ifdef SHIFTADD_DOT_TIMEOUT_EN
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            // The multiplier has no reset: let any operation that was in
            // flight at reset run out before a new start is issued.
            S_GUARD: begin
               if (r_tick_cnt == TW'(GUARD_CYC - 1)) begin
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b1;
               end else begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
            end
            S_IDLE: begin
               if (i_in_valid && r_in_ready) begin
                  r_mul_a     <= i_in_a;
                  r_mul_b     <= i_in_b;
                  r_last      <= i_in_last;
                  r_mul_start <= 1'b1;
                  r_in_ready  <= 1'b0;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mul_start <= 1'b0;
               r_tick_cnt  <= '0;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               // Operands stay untouched here: the multiplier reads b
               // combinationally for the whole operation.
               if (i_mul_flag) begin
                  r_sum <= w_sum_add;
                  r_cnt <= w_cnt_inc;
                  if (r_last || (w_cnt_inc == CNT_W'(MAX_LEN))) begin
                     r_out_valid <= 1'b1;
                     r_trunc     <= ~r_last;
                     r_state     <= S_DONE;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
`ifdef SHIFTADD_DOT_TIMEOUT_EN
               else if (r_tick_cnt == TW'(TMO_CYC - 1)) begin
                  // Multiplier never answered: drop the vector and re-guard.
                  r_err      <= 1'b1;
                  r_sum      <= '0;
                  r_cnt      <= '0;
                  r_trunc    <= 1'b0;
                  r_tick_cnt <= '0;
                  r_state    <= S_GUARD;
               end else begin
                  r_tick_cnt <= r_tick_cnt + TW'(1);
               end
`endif
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_sum       <= '0;
                  r_cnt       <= '0;
                  r_trunc     <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_GUARD;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_mul_start = r_mul_start;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;
   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_sum;
   assign o_out_cnt   = r_cnt;
   assign o_out_trunc = r_trunc;

endmodule

// File: tb/tb_shiftadd_dot_seq.sv
// ============================================================================
// tb_shiftadd_dot_seq
//
// Bench for shiftadd_dot_seq. A behavioural 4x4 shift-add multiplier (no
// reset, latency 6 + popcount(a) cycles from accept edge to capture edge)
// answers the sequencer. Expected vector results, operands and latencies are
// pushed to queues by the driver and popped by the monitor. Inputs change
// 1ns after the rising edge; outputs are sampled on the falling edge.
// ============================================================================
module tb_shiftadd_dot_seq;

   localparam int MAX_LEN = 16;
   localparam int CNT_W   = 5;
   localparam int SUM_W   = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_a = '0;
   logic [3:0]       in_b = '0;
   logic             in_last = 1'b0;
   logic             mul_start;
   logic [3:0]       mul_a;
   logic [3:0]       mul_b;
   logic             mul_flag = 1'b0;
   logic [7:0]       mul_prod;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [SUM_W-1:0] out_sum;
   logic [CNT_W-1:0] out_cnt;
   logic             out_trunc;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int sum;
      int cnt;
      int trunc;
   } res_t;

   res_t       exp_q[$];
   int         lat_q[$];
   logic [7:0] op_q[$];

   bit         mul_en = 1'b1;
   logic [3:0] m_a = '0;
   logic [3:0] m_b = '0;
   logic [3:0] va[MAX_LEN];
   logic [3:0] vb[MAX_LEN];

   shiftadd_dot_seq dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_in_a     (in_a),
      .i_in_b     (in_b),
      .i_in_last  (in_last),
      .o_mul_start(mul_start),
      .o_mul_a    (mul_a),
      .o_mul_b    (mul_b),
      .i_mul_flag (mul_flag),
      .i_mul_prod (mul_prod),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_out_sum  (out_sum),
      .o_out_cnt  (out_cnt),
      .o_out_trunc(out_trunc),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Multiplier model: product is garbage except while the flag is high.
   assign mul_prod = mul_flag ? ({4'b0, m_a} * {4'b0, m_b}) : 8'h5A;

   initial begin
      forever begin
         @(negedge clk);
         if (mul_start && mul_en) begin
            m_a = mul_a;
            m_b = mul_b;
            repeat (6 + $countones(m_a) - 1) @(posedge clk);
            #1 mul_flag = 1'b1;
            @(posedge clk);
            #1 mul_flag = 1'b0;
         end
      end
   end

   // Monitor
   int         cyc = 0;
   int         t_start = 0;
   bit         busy = 1'b0;
   bit         prev_start = 1'b0;
   logic [3:0] st_a, st_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 1'b0;
         lat_q.delete();
         op_q.delete();
      end else begin
         if (prev_start)
            check_val("start_pulse_width", int'(mul_start), 0);
         if (mul_start && !prev_start) begin
            if (op_q.size() == 0) begin
               check_val("unexpected_start", 1, 0);
            end else begin
               logic [7:0] ex;
               ex = op_q.pop_front();
               check_val("mul_a", int'(mul_a), int'(ex[7:4]));
               check_val("mul_b", int'(mul_b), int'(ex[3:0]));
            end
            st_a    = mul_a;
            st_b    = mul_b;
            t_start = cyc;
            busy    = 1'b1;
         end
         if (mul_flag && busy) begin
            if (lat_q.size() == 0) check_val("unexpected_flag", 1, 0);
            else check_val("pair_latency", cyc - t_start + 1, lat_q.pop_front());
            check_val("hold_mul_a", int'(mul_a), int'(st_a));
            check_val("hold_mul_b", int'(mul_b), int'(st_b));
            busy = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_out", 1, 0);
            end else begin
               res_t r;
               r = exp_q.pop_front();
               $display("OUT sum=%0d cnt=%0d trunc=%0d (exp %0d/%0d/%0d)",
                        out_sum, out_cnt, out_trunc, r.sum, r.cnt, r.trunc);
               check_val("out_sum", int'(out_sum), r.sum);
               check_val("out_cnt", int'(out_cnt), r.cnt);
               check_val("out_trunc", int'(out_trunc), r.trunc);
            end
         end
      end
      prev_start = mul_start;
      cyc++;
   end

   task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
      int n;
      n        = 0;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check_val("accept_timeout", 0, 1);
      end else begin
         op_q.push_back({a, b});
         lat_q.push_back(6 + $countones(a));
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sends va/vb[0..len-1]; in_last on the final pair when use_last is set.
   task automatic send_vec(input int len, input bit use_last);
      res_t r;
      r.sum = 0;
      for (int i = 0; i < len; i++) r.sum += int'(va[i]) * int'(vb[i]);
      r.cnt   = len;
      r.trunc = (len == MAX_LEN && !use_last) ? 1 : 0;
      exp_q.push_back(r);
      for (int i = 0; i < len; i++)
         send_pair(va[i], vb[i], use_last && (i == len - 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
      tick();
   endtask

   task automatic count_guard(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         n++;
         tick();
      end
      check_val(tag, n, 10);
   endtask

   initial begin
      int n;
      // Reset
      rst_n = 1'b0;
      tick();
      tick();
      check_val("rst_in_ready", int'(in_ready), 0);
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_out_sum", int'(out_sum), 0);
      check_val("rst_out_cnt", int'(out_cnt), 0);
      check_val("rst_mul_start", int'(mul_start), 0);
      check_val("rst_err", int'(err), 0);
      rst_n = 1'b1;
      count_guard("guard_cycles");

      // Basic vector: 15 + 225 + 0
      va[0] = 4'd3;  vb[0] = 4'd5;
      va[1] = 4'd15; vb[1] = 4'd15;
      va[2] = 4'd0;  vb[2] = 4'd9;
      send_vec(3, 1'b1);
      drain();

      // Count-limit termination
      for (int i = 0; i < MAX_LEN; i++) begin
         va[i] = 4'd15;
         vb[i] = 4'd15;
      end
      send_vec(MAX_LEN, 1'b0);
      drain();

      // Back-pressure in DONE
      out_ready = 1'b0;
      va[0] = 4'd1; vb[0] = 4'd2;
      va[1] = 4'd3; vb[1] = 4'd4;
      send_vec(2, 1'b1);
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check_val("hold_out_valid", int'(out_valid), 1);
         check_val("hold_out_sum", int'(out_sum), 14);
         check_val("hold_out_cnt", int'(out_cnt), 2);
         check_val("hold_in_ready", int'(in_ready), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check_val("release_in_ready", int'(in_ready), 1);
      check_val("release_out_valid", int'(out_valid), 0);
      check_val("release_out_sum", int'(out_sum), 0);
      check_val("release_out_cnt", int'(out_cnt), 0);
      va[0] = 4'd7; vb[0] = 4'd7;
      send_vec(1, 1'b1);
      drain();

      // Random short vectors
      for (int v = 0; v < 4; v++) begin
         int len;
         len = int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            va[i] = 4'($urandom_range(0, 15));
            vb[i] = 4'($urandom_range(0, 15));
         end
         send_vec(len, 1'b1);
         drain();
      end

      // Reset during WAIT of pair 2 (a=15, product still in flight)
      send_pair(4'd1, 4'd1, 1'b0);
      send_pair(4'd15, 4'd15, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check_val("midrst_out_valid", int'(out_valid), 0);
      check_val("midrst_out_sum", int'(out_sum), 0);
      check_val("midrst_out_cnt", int'(out_cnt), 0);
      check_val("midrst_in_ready", int'(in_ready), 0);
      check_val("midrst_mul_a", int'(mul_a), 0);
      rst_n = 1'b1;
      count_guard("midrst_guard_cycles");
      va[0] = 4'd2; vb[0] = 4'd2;
      send_vec(1, 1'b1);
      drain();
      check_val("err_quiet", int'(err), 0);

`ifdef SHIFTADD_DOT_TIMEOUT_EN
      // Multiplier never answers
      mul_en = 1'b0;
      send_pair(4'd1, 4'd1, 1'b0);
      n = 0;
      while (!err && n < 50) begin
         tick();
         n++;
      end
      check_val("timeout_cycles", n, 13);
      count_guard("timeout_guard_cycles");
      check_val("err_sticky", int'(err), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
